uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per UART bit (100 MHz / 115200); legal values are 4 and above.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, giving the receive FIFO entry count; legal values are powers of two, 2 and above.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; every flop is clocked on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port i_uart_rx, input, 1 bit, the asynchronous serial line (idle high), driven by the SoC's o_uart_tx.
REQ-006 The block SHALL have port o_data, output, 8 bits, the byte at the FIFO head.
REQ-007 The block SHALL have port o_valid, output, 1 bit, high when the FIFO is non-empty.
REQ-008 The block SHALL have port i_ready, input, 1 bit; the consumer accepts o_data when o_valid and i_ready are both high.
REQ-009 The block SHALL have port o_count, output, $clog2(FIFO_DEPTH)+1 bits, the current FIFO occupancy.
REQ-010 The block SHALL have port o_frame_err, output, 1 bit, a one-cycle pulse when a frame is rejected.
REQ-011 The block SHALL have port o_overrun, output, 1 bit, a sticky flag set when a good byte is lost because the FIFO is full.
REQ-012 The block SHALL have port i_clr, input, 1 bit, which clears o_overrun.

Function
REQ-013 i_uart_rx SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value rx_s.
REQ-014 The receive FSM SHALL have states IDLE, START, DATA, PARITY (present only with the Configuration macro) and STOP, plus a bit-timer and a 3-bit bit index.
REQ-015 In IDLE, rx_s = 0 SHALL move the FSM to START and load the timer with CLKS_PER_BIT/2 - 1.
REQ-016 START: when the timer expires, rx_s = 1 SHALL be treated as a glitch (return to IDLE, no error); rx_s = 0 SHALL move to DATA with the timer reloaded to CLKS_PER_BIT - 1.
REQ-017 DATA SHALL sample rx_s at each timer expiry, LSB first, into bit index 0..7, then move to PARITY or STOP.
REQ-018 STOP SHALL sample at timer expiry: rx_s = 1 with no parity error pushes the byte; otherwise o_frame_err pulses for exactly one cycle and the byte is discarded. Either way the FSM returns to IDLE in the same cycle.
REQ-019 A pushed byte SHALL be visible on o_valid/o_data in the cycle after the STOP sample (latency 1).
REQ-020 A pop SHALL occur on o_valid & i_ready. o_data SHALL show the new head in the next cycle. i_ready while empty SHALL have no effect.
REQ-021 Push while full with no pop SHALL drop the byte and set o_overrun. Push while full with a simultaneous pop SHALL succeed and leave o_count unchanged.
REQ-022 A simultaneous push and pop at any other occupancy SHALL leave o_count unchanged. Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 If i_clr coincides with an overrun, set SHALL take priority (o_overrun stays 1).
REQ-024 A new start bit SHALL be accepted in the first IDLE cycle after STOP; back-to-back frames SHALL be received without loss.

Reset
REQ-025 reset SHALL force: FSM to IDLE, timer and bit index to 0, pointers and o_count to 0, o_valid 0, o_frame_err 0, o_overrun 0, o_data 8'h00, and both synchronizer flops to 1.
REQ-026 A reset asserted mid-frame SHALL abandon the frame with no push and no error pulse; the next falling edge after reset SHALL start a fresh frame.

Configuration
REQ-027 With UART_RX_PARITY_EN defined, frames SHALL be 8E1: the PARITY state samples one bit, and odd total parity over data plus parity bit SHALL cause a frame error in STOP.
REQ-028 Without UART_RX_PARITY_EN, frames SHALL be 8N1 and no PARITY state or logic SHALL exist.

Verification
REQ-029 Scenario: CLKS_PER_BIT=16, send 8'hA5 in 8N1 → o_valid rises 1 cycle after the STOP sample, o_data=8'hA5, o_count=1.
REQ-030 Scenario: send 8'h00 then 8'hFF back-to-back with i_ready=0 → o_count=2, then pop order is 8'h00 then 8'hFF.
REQ-031 Scenario: send 8'h3C with the stop bit forced to 0 → one-cycle o_frame_err pulse, o_count stays 0.
REQ-032 Scenario: FIFO_DEPTH=8, send 9 bytes with i_ready=0 → o_count=8, o_overrun=1, FIFO holds bytes 1..8; then pulse i_clr → o_overrun=0.
REQ-033 Scenario: low glitch of 4 clks on i_uart_rx (CLKS_PER_BIT=16) → no push and no o_frame_err.
REQ-034 Scenario: assert reset at bit 4 of 8'h81 → no push; the following frame 8'h42 is received correctly. With UART_RX_PARITY_EN, 8'h42 sent with bad parity → o_frame_err pulses.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Brief    : UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN defined)
//             feeding a power-of-two receive FIFO with valid/ready pop side,
//             frame-error pulse and sticky overrun flag.
//  Options  : `define UART_RX_PARITY_EN to receive 8E1 frames.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          i_uart_rx,
   output logic [7:0]                    o_data,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_count,
   output logic                          o_frame_err,
   output logic                          o_overrun,
   input  logic                          i_clr
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [TW-1:0] T_HALF  = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] T_FULL  = TW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   // ------------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------------
   logic          sync_1;
   logic          rx_s;
   state_t        state;
   logic [TW-1:0] timer;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          frame_err;
   logic          tick;
   logic          par_err;
   logic          stop_good;
   logic          push_req;

`ifdef UART_RX_PARITY_EN
   logic          par_bit;
   // Even parity: data plus parity bit must XOR to zero.
   assign par_err = ^{shreg, par_bit};
`else
   assign par_err = 1'b0;
`endif

   assign tick      = (timer == '0);
   assign stop_good = rx_s & ~par_err;
   assign push_req  = (state == STOP) & tick & stop_good;

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1 <= 1'b1;
         rx_s   <= 1'b1;
      end else begin
         sync_1 <= i_uart_rx;
         rx_s   <= sync_1;
      end
   end

   // Receive FSM: half-bit to the start-bit centre, then full-bit strides.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         timer     <= '0;
         bit_idx   <= 3'd0;
         shreg     <= 8'h00;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit   <= 1'b0;
`endif
      end else begin
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  timer <= T_HALF;
               end
            end
            START: begin
               if (tick) begin
                  if (rx_s) begin
                     state <= IDLE;          // start bit vanished: glitch
                  end else begin
                     state   <= DATA;
                     timer   <= T_FULL;
                     bit_idx <= 3'd0;
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            DATA: begin
               if (tick) begin
                  shreg[bit_idx] <= rx_s;
                  timer          <= T_FULL;
                  bit_idx        <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  par_bit <= rx_s;
                  timer   <= T_FULL;
                  state   <= STOP;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  frame_err <= ~stop_good;
                  state     <= IDLE;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Receive FIFO
   // ------------------------------------------------------------------------
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          overrun;
   logic          pop;
   logic          full;
   logic          do_push;
   logic          overflow;

   assign pop      = o_valid & i_ready;
   assign full     = (count == DEPTH_C);
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign do_push  = push_req & (~full | pop);
   assign overflow = push_req & full & ~pop;

   // Storage, pointers (wrap naturally at power-of-two depth) and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= 8'h00;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky overrun; a new overflow wins over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (overflow) begin
         overrun <= 1'b1;
      end else if (i_clr) begin
         overrun <= 1'b0;
      end
   end

   assign o_data      = mem[rd_ptr];
   assign o_valid     = (count != '0);
   assign o_count     = count;
   assign o_frame_err = frame_err;
   assign o_overrun   = overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Brief    : Directed self-checking bench for uart_rx_fifo (CLKS_PER_BIT=16,
//             FIFO_DEPTH=8). Honours UART_RX_PARITY_EN for 8E1 frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

   localparam int CPB   = 16;
   localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   // Line fall -> o_valid seen on a negedge: 2 sync + 1 idle detect
   // + half bit + remaining (NBITS-1) full bits up to the stop sample.
   localparam int LAT = 3 + CPB / 2 + (NBITS - 1) * CPB;

   logic       clk;
   logic       reset;
   logic       i_uart_rx;
   logic [7:0] o_data;
   logic       o_valid;
   logic       i_ready;
   logic [3:0] o_count;
   logic       o_frame_err;
   logic       o_overrun;
   logic       i_clr;

   int checks   = 0;
   int failures = 0;
   int rise;
   int ferr;

   uart_rx_fifo #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .i_uart_rx   (i_uart_rx),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_count     (o_count),
      .o_frame_err (o_frame_err),
      .o_overrun   (o_overrun),
      .i_clr       (i_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one frame starting at the current negedge. rst_bit = data bit
   // index at whose start reset is raised (held to frame end); 99 = none.
   task automatic send_frame(input logic [7:0] d, input logic stop_v,
                             input logic par_flip, input int rst_bit,
                             output int rise_at, output int ferr_n);
      logic [10:0] frame;
      logic [3:0]  base;
      int          idx;
      frame = '1;
      frame[0]   = 1'b0;
      frame[8:1] = d;
`ifdef UART_RX_PARITY_EN
      frame[9]  = (^d) ^ par_flip;
      frame[10] = stop_v;
`else
      frame[9]  = stop_v;
`endif
      base    = o_count;
      rise_at = -1;
      ferr_n  = 0;
      idx     = 0;
      for (int b = 0; b < NBITS; b++) begin
         if (b == rst_bit + 1) reset = 1'b1;
         i_uart_rx = frame[b];
         repeat (CPB) begin
            @(negedge clk);
            idx++;
            if (o_frame_err) ferr_n++;
            if (rise_at < 0 && o_count != base) rise_at = idx;
         end
      end
      reset = 1'b0;
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] exp);
      check({tag, "_valid"}, o_valid, 1'b1);
      check({tag, "_data"}, o_data, exp);
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      i_uart_rx = 1'b1;
      i_ready   = 1'b0;
      i_clr     = 1'b0;
      repeat (4) @(negedge clk);

      // Reset state
      check("rst_valid",   o_valid,     1'b0);
      check("rst_count",   o_count,     4'd0);
      check("rst_ferr",    o_frame_err, 1'b0);
      check("rst_overrun", o_overrun,   1'b0);
      check("rst_data",    o_data,      8'h00);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // Single byte, latency and head data
      send_frame(8'hA5, 1'b1, 1'b0, 99, rise, ferr);
      check("a5_latency", rise,    LAT);
      check("a5_count",   o_count, 4'd1);
      check("a5_ferr",    ferr,    0);
      pop_expect("a5", 8'hA5);
      check("a5_empty", o_count, 4'd0);

      // Back-to-back frames, ordering
      send_frame(8'h00, 1'b1, 1'b0, 99, rise, ferr);
      send_frame(8'hFF, 1'b1, 1'b0, 99, rise, ferr);
      check("b2b_count", o_count, 4'd2);
      pop_expect("b2b_first", 8'h00);
      check("b2b_count1", o_count, 4'd1);
      pop_expect("b2b_second", 8'hFF);
      check("b2b_empty", o_count, 4'd0);

      // Bad stop bit
      send_frame(8'h3C, 1'b0, 1'b0, 99, rise, ferr);
      check("stop_ferr_pulses", ferr, 1);
      i_uart_rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check("stop_count", o_count, 4'd0);

      // Short low glitch
      i_uart_rx = 1'b0;
      repeat (4) @(negedge clk);
      i_uart_rx = 1'b1;
      ferr = 0;
      repeat (3 * CPB) begin
         @(negedge clk);
         if (o_frame_err) ferr++;
      end
      check("glitch_count", o_count, 4'd0);
      check("glitch_ferr",  ferr,    0);

      // Overrun: 9 bytes into 8 entries (pointers wrap as well)
      for (int k = 1; k <= 9; k++) begin
         send_frame(8'(k), 1'b1, 1'b0, 99, rise, ferr);
      end
      check("ovr_count", o_count,   4'd8);
      check("ovr_flag",  o_overrun, 1'b1);
      i_clr = 1'b1;
      @(negedge clk);
      i_clr = 1'b0;
      check("ovr_cleared", o_overrun, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         pop_expect("ovr_pop", 8'(k));
      end
      check("ovr_empty", o_count, 4'd0);

      // Reset during data bit 4, then a clean frame
      send_frame(8'h81, 1'b1, 1'b0, 4, rise, ferr);
      check("midrst_count", o_count, 4'd0);
      check("midrst_ferr",  ferr,    0);
      send_frame(8'h42, 1'b1, 1'b0, 99, rise, ferr);
      check("after_rst_count", o_count, 4'd1);
      pop_expect("after_rst", 8'h42);

`ifdef UART_RX_PARITY_EN
      // Bad parity
      send_frame(8'h42, 1'b1, 1'b1, 99, rise, ferr);
      check("par_ferr",  ferr,    1);
      check("par_count", o_count, 4'd0);
`endif

      // Ready while empty has no effect
      i_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("empty_ready_count", o_count, 4'd0);
      check("empty_ready_valid", o_valid, 1'b0);
      i_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
